ps_frame_feeder: RTL and testbench
==================================

# ps_frame_feeder

Streams windowed frames of signed samples into `ps_comp_unit`, acting as the producer of its `din`/`en` input. Incoming samples are buffered in a ring buffer. Once a full window is available, the block emits the window as a burst of consecutive `en` cycles, then waits for the power-spectrum unit's `data_valid` before starting the next window. Windows may overlap by `WIN_LEN - HOP` samples. The block sits between the sample acquisition front end and `ps_comp_unit`.

## Interface
- `DATA_WIDTH`, 32, sample width (signed); matches `ps_comp_unit` `input_width`
- `WIN_LEN`, 64, samples per window
- `HOP`, 32, samples retired per window; 1 <= `HOP` <= `WIN_LEN`
- `DEPTH`, 128, ring buffer depth; power of 2, >= `WIN_LEN`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `din`  in  `DATA_WIDTH`  signed input sample
- `din_valid`  in  1  `din` is written this cycle
- `ps_done`  in  1  `data_valid` pulse from `ps_comp_unit`
- `dout`  out  `DATA_WIDTH`  signed sample to `ps_comp_unit` `din`
- `en`  out  1  `dout` valid; drives `ps_comp_unit` `en`
- `frame_start`  out  1  high with the first sample of a window
- `frame_last`  out  1  high with the last sample of a window
- `busy`  out  1  high in STREAM and WAIT_DONE
- `overflow`  out  1  sticky flag; set when a sample is dropped

## Operation
- Reset values: `dout` = 0. `en`, `frame_start`, `frame_last`, `busy`, `overflow` = 0. `wr_ptr`, `rd_ptr`, `count` = 0. State = IDLE. Buffer contents are don't-care.
- Write: when `din_valid` is high and `count < DEPTH`, write to `buf[wr_ptr]` and increment `wr_ptr` mod `DEPTH`.
- Overflow: when `din_valid` is high and `count == DEPTH`, drop the sample and set `overflow`. Only reset clears `overflow`.
- `count` next = `count` + write − (`HOP` if retiring this cycle). A write and a retire in the same cycle are both applied.
- FSM:
  - IDLE: if `count >= WIN_LEN`, go to STREAM and clear `k` = 0.
  - STREAM: drive `dout` = `buf[rd_ptr + k]` (index mod `DEPTH`) with `en` = 1, for `k` = 0..`WIN_LEN`−1. At `k == WIN_LEN`−1, retire: `rd_ptr` += `HOP`, `count` −= `HOP`, go to WAIT_DONE.
  - WAIT_DONE: on `ps_done`, go to IDLE. `en` = 0.
- `ps_done` arriving in IDLE or STREAM is ignored; it is not latched.
- Samples written during STREAM or WAIT_DONE are buffered normally and never disturb the window being streamed.
- `HOP == WIN_LEN` gives non-overlapping windows.

## Timing
- All outputs are registered.
- `count` reaches `WIN_LEN` at edge t (while in IDLE). IDLE observes it in the following cycle. At edge t+1: state = STREAM, `en` = 1, `dout` = sample 0, `frame_start` = 1.
- `en` stays high for exactly `WIN_LEN` consecutive cycles with no gaps.
- `frame_last` coincides with the last `en` cycle. `en` drops at the next edge.
- `busy` rises with the first `en` and falls at the edge following the `ps_done` cycle.
- The earliest next window begins 2 edges after the `ps_done` cycle (the IDLE evaluation cycle, then STREAM).
- Asynchronous reset mid-operation: `en`, `frame_start`, `frame_last`, and `busy` drop immediately. The partial frame is abandoned and all buffered samples are discarded.

## Structure
- Package `ps_pkg` holds:
  - the `DATA_WIDTH` default,
  - the FSM state enum (IDLE, STREAM, WAIT_DONE),
  - a `clog2`-based pointer-width constant.
- Sub-module `sample_ring_buffer`: holds storage, `wr_ptr`, `count`, and the overflow logic, with a random-read port. The top level holds the FSM, `k`, `rd_ptr`, and the output registers.

## Test plan
All scenarios use `WIN_LEN`=4, `HOP`=2, `DEPTH`=8.
- Write samples 1,2,3,4 on consecutive cycles -> `en` high for 4 cycles; `dout` = 1,2,3,4; `frame_start` high on 1, `frame_last` high on 4; `busy` = 1; `count` = 2 afterward.
- After the first frame, write 5,6, then pulse `ps_done` -> second frame `dout` = 3,4,5,6; `en` rises 2 edges after `ps_done`.
- Write 7 during STREAM on the `frame_last` cycle -> `count` = 2 + 1 − 2 + prior, with no lost sample; the next frame includes 7 in order.
- Hold `ps_done` low after a frame and write 7 more samples -> the 7th extra sample (`count` = 8 full) is dropped; `overflow` = 1 and stays 1 through later `ps_done`.
- Pulse `ps_done` while IDLE with `count` < 4 -> no state change, `en` stays 0.
- Assert `rst` during the 3rd `en` cycle of a frame -> `en`, `busy`, `dout` go to 0 immediately. After release, writing 9,10,11,12 yields a frame of 9,10,11,12.

Source files
------------

// File: rtl/ps_pkg.sv
// Shared definitions for the power-spectrum frame feeder.
//   DATA_WIDTH_DEFAULT : default signed sample width
//   DEPTH_DEFAULT      : default ring buffer depth
//   PTR_W_DEFAULT      : ring pointer width for the default depth
//   state_t            : feeder FSM states
//   ptr_width()        : ring pointer width for a given depth
package ps_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT      = 128;
  localparam int unsigned PTR_W_DEFAULT      = $clog2(DEPTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Sample ring buffer with a random-access read port.
//   clk, rst      : clock, asynchronous active-high reset
//   din/din_valid : sample write; dropped when the buffer is full
//   retire        : release HOP samples from the occupancy count
//   rd_addr       : combinational read address
//   rd_data       : sample at rd_addr
//   count         : number of buffered samples (0..DEPTH)
//   overflow      : sticky, set when a sample was dropped
module sample_ring_buffer
  import ps_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = DEPTH_DEFAULT,
  parameter int unsigned HOP        = 32,
  localparam int unsigned PTR_W     = ptr_width(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         din_valid,
  input  logic                         retire,
  input  logic        [PTR_W-1:0]      rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic        [CNT_W-1:0]      count,
  output logic                         overflow
);

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full;
  logic             wr_en;

  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    wr_en      = din_valid && !full;
    wr_ptr_d   = wr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    // A write and a retire in the same cycle both take effect.
    count_d    = count_q + CNT_W'(wr_en) - (retire ? CNT_W'(HOP) : '0);
    overflow_d = overflow_q | (din_valid & full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign rd_data  = mem_q[rd_addr];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/ps_frame_feeder.sv
// Feeds overlapping windows of buffered samples to ps_comp_unit.
//   clk, rst      : clock, asynchronous active-high reset
//   din/din_valid : incoming signed samples
//   ps_done       : data_valid pulse from ps_comp_unit
//   dout/en       : window samples, WIN_LEN consecutive en cycles
//   frame_start   : first sample of a window
//   frame_last    : last sample of a window
//   busy          : streaming or waiting for ps_done
//   overflow      : sticky sample-drop flag
module ps_frame_feeder
  import ps_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned HOP        = 32,
  parameter int unsigned DEPTH      = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         din_valid,
  input  logic                         ps_done,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         en,
  output logic                         frame_start,
  output logic                         frame_last,
  output logic                         busy,
  output logic                         overflow
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  state_t                       state_q, state_d;
  logic        [CNT_W-1:0]      k_q, k_d;
  logic        [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                         en_q, en_d;
  logic                         frame_start_q, frame_start_d;
  logic                         frame_last_q, frame_last_d;
  logic                         busy_q, busy_d;

  logic                         retire;
  logic        [PTR_W-1:0]      rd_addr;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic        [CNT_W-1:0]      count;

  sample_ring_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .HOP        (HOP)
  ) u_rb (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .retire    (retire),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .count     (count),
    .overflow  (overflow)
  );

  // k_q is the index of the next sample to fetch; the output registers
  // present sample k_q-1, so the retire happens while the last sample
  // is on dout (the frame_last cycle).
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    rd_ptr_d      = rd_ptr_q;
    dout_d        = '0;
    en_d          = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
    retire        = 1'b0;
    rd_addr       = rd_ptr_q + k_q[PTR_W-1:0];

    case (state_q)
      IDLE: begin
        if (count >= CNT_W'(WIN_LEN)) begin
          state_d       = STREAM;
          k_d           = CNT_W'(1);
          dout_d        = rd_data;
          en_d          = 1'b1;
          frame_start_d = 1'b1;
          frame_last_d  = (WIN_LEN == 1);
        end
      end
      STREAM: begin
        if (k_q == CNT_W'(WIN_LEN)) begin
          retire   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_W'(HOP);
          k_d      = '0;
          state_d  = WAIT_DONE;
        end else begin
          dout_d       = rd_data;
          en_d         = 1'b1;
          frame_last_d = (k_q == CNT_W'(WIN_LEN - 1));
          k_d          = k_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (ps_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      rd_ptr_q      <= '0;
      dout_q        <= '0;
      en_q          <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      rd_ptr_q      <= rd_ptr_d;
      dout_q        <= dout_d;
      en_q          <= en_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
      busy_q        <= busy_d;
    end
  end

  assign dout        = dout_q;
  assign en          = en_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ps_frame_feeder.sv
module tb_ps_frame_feeder;

  localparam int DW      = 32;
  localparam int WIN_LEN = 4;
  localparam int HOP     = 2;
  localparam int DEPTH   = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic                 ps_done = 1'b0;
  logic signed [DW-1:0] dout;
  logic                 en, frame_start, frame_last, busy, overflow;

  ps_frame_feeder #(
    .DATA_WIDTH (DW),
    .WIN_LEN    (WIN_LEN),
    .HOP        (HOP),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .ps_done     (ps_done),
    .dout        (dout),
    .en          (en),
    .frame_start (frame_start),
    .frame_last  (frame_last),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] d;
    bit                   s;
    bit                   l;
  } sb_t;

  // Reference model: the accepted sample stream; window n is
  // stream[n*HOP +: WIN_LEN].
  logic signed [DW-1:0] hist[$];
  sb_t                  exp_q[$];
  int                   nf = 0;
  int                   frames_done = 0;
  int                   base = 0;
  int                   n_cmp = 0;
  int                   n_bad = 0;
  sb_t                  mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frames();
    while (hist.size() >= nf * HOP + WIN_LEN) begin
      for (int j = 0; j < WIN_LEN; j++) begin
        sb_t e;
        e.d = hist[nf * HOP + j];
        e.s = (j == 0);
        e.l = (j == WIN_LEN - 1);
        exp_q.push_back(e);
      end
      nf++;
    end
  endtask

  function automatic int occupancy();
    return hist.size() - HOP * (frames_done - base);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic signed [DW-1:0] v);
    din       = v;
    din_valid = 1'b1;
    if (occupancy() < DEPTH) begin
      hist.push_back(v);
      push_frames();
    end
    tick();
    din_valid = 1'b0;
  endtask

  task automatic model_clear();
    hist.delete();
    exp_q.delete();
    nf   = 0;
    base = frames_done;
  endtask

  task automatic wait_en(input string nm);
    int t = 0;
    while (!en && t < 50) begin
      tick();
      t++;
    end
    if (!en) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for en", nm);
    end
  endtask

  task automatic wait_stream_end(input string nm);
    int t = 0;
    while (!(busy && !en) && t < 50) begin
      tick();
      t++;
    end
    if (!(busy && !en)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for end of frame", nm);
    end
  endtask

  // Monitor: every en cycle pops one expected sample.
  always @(negedge clk) begin
    if (!rst && en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_en: got dout %0h with empty scoreboard at %0t", dout, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout", dout, mon_e.d);
        chk("frame_start", frame_start, mon_e.s);
        chk("frame_last", frame_last, mon_e.l);
        chk("busy_in_stream", busy, 1);
        if (mon_e.l) frames_done++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    tick(); tick();
    rst = 1'b0;
    model_clear();
    chk("rst_en", en, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", dut.u_rb.count_q, 0);

    // First window 1..4, latency and length
    for (int i = 1; i <= 4; i++) put(i);
    chk("lat_pre_en", en, 0);
    tick();
    chk("lat_en", en, 1);
    chk("lat_start", frame_start, 1);
    n = 1;
    while (en && n < 20) begin
      tick();
      if (en) n++;
    end
    chk("en_len", n, WIN_LEN);
    chk("busy_wait", busy, 1);
    chk("count_after_1", dut.u_rb.count_q, 2);

    // Second window 3..6 starts two edges after ps_done
    put(5); put(6);
    ps_done = 1'b1;
    tick();
    ps_done = 1'b0;
    chk("done_busy_fall", busy, 0);
    chk("done_en_low", en, 0);
    tick();
    chk("done_en_rise", en, 1);
    chk("done_start", frame_start, 1);
    n = 0;
    while (!frame_last && n < 20) begin
      tick();
      n++;
    end
    chk("reach_last", frame_last, 1);
    put(7);   // written on the frame_last cycle, same edge as the retire
    chk("count_wr_retire", dut.u_rb.count_q, 3);
    chk("wait_after_2", busy && !en, 1);

    // Overflow while held in WAIT_DONE
    chk("ovf_before", overflow, 0);
    for (int i = 0; i < 6; i++) put(100 + i);
    chk("ovf_set", overflow, 1);
    chk("count_full", dut.u_rb.count_q, DEPTH);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic signed [DW-1:0] v;
      v = $urandom;
      if ($urandom_range(0, 1) == 1 && occupancy() <= DEPTH - HOP - 1) begin
        din       = v;
        din_valid = 1'b1;
        hist.push_back(v);
        push_frames();
      end else begin
        din_valid = 1'b0;
      end
      ps_done = ($urandom_range(0, 2) == 0);
      tick();
    end
    din_valid = 1'b0;
    ps_done   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      ps_done = busy && !en;
      tick();
    end
    ps_done = 1'b0;
    chk("drain_empty", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);

    // Reset in the third en cycle of a frame
    rst = 1'b1;
    tick();
    model_clear();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) put(i);
    wait_en("rst_frame_start");
    tick(); tick();
    chk("third_en", en, 1);
    rst = 1'b1;
    model_clear();
    #1;
    chk("arst_en", en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_dout", dout, 0);
    chk("arst_last", frame_last, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_count", dut.u_rb.count_q, 0);
    tick();
    rst = 1'b0;
    for (int i = 9; i <= 12; i++) put(i);
    wait_stream_end("post_rst_frame");

    // ps_done while IDLE with count < WIN_LEN is ignored
    ps_done = 1'b1;
    tick();
    ps_done = 1'b0;
    chk("idle_count", dut.u_rb.count_q, 2);
    ps_done = 1'b1;
    tick();
    ps_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_done_en", en, 0);
      chk("idle_done_busy", busy, 0);
      tick();
    end
    chk("final_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
